// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the 7-source common-bus arbiter: source indices, bus select codes,
// sequencer state encodings and the index-to-select-code helper.
package bus_arbiter_pkg;

    localparam int unsigned SRC_AR = 0;
    localparam int unsigned SRC_PC = 1;
    localparam int unsigned SRC_DR = 2;
    localparam int unsigned SRC_AC = 3;
    localparam int unsigned SRC_IR = 4;
    localparam int unsigned SRC_TR = 5;
    localparam int unsigned SRC_M  = 6;

    localparam logic [2:0] SEL_IDLE = 3'b000;
    localparam logic [2:0] SEL_AR   = 3'b001;
    localparam logic [2:0] SEL_PC   = 3'b010;
    localparam logic [2:0] SEL_DR   = 3'b011;
    localparam logic [2:0] SEL_AC   = 3'b100;
    localparam logic [2:0] SEL_IR   = 3'b101;
    localparam logic [2:0] SEL_TR   = 3'b110;
    localparam logic [2:0] SEL_M    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_MWAIT = 2'd2
    } state_e;

    // Select code 0 is reserved for an idle bus, so source i drives code i+1.
    function automatic logic [2:0] sel_encode(input int unsigned idx);
        return 3'(idx + 1);
    endfunction

endpackage

// File: rtl/bus_pick.sv
// Combinational winner selection over req & ~mask: fixed priority (highest index) or
// round-robin searching upward from last+1 with wrap.
module bus_pick #(
    parameter int unsigned NSRC = 7,
    parameter bit          RR   = 1'b0,
    parameter int unsigned IdxW = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] req,
    input  logic [NSRC-1:0] mask,
    input  logic [IdxW-1:0] last,
    output logic [IdxW-1:0] winner,
    output logic            valid
);

    logic [NSRC-1:0] elig;
    logic            unused_last;
    int              j;

    assign elig        = req & ~mask;
    assign valid       = |elig;
    assign unused_last = ^last;

    always_comb begin
        winner = '0;
        j      = 0;
        if (RR) begin
            // Walk offsets from far to near so the nearest eligible source after last wins.
            for (int k = int'(NSRC) - 1; k >= 0; k--) begin
                j = int'(last) + k + 1;
                if (j >= int'(NSRC)) begin
                    j = j - int'(NSRC);
                end
                if (elig[j]) begin
                    winner = IdxW'(j);
                end
            end
        end else begin
            for (int i = 0; i < int'(NSRC); i++) begin
                if (elig[i]) begin
                    winner = IdxW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Common-bus arbiter/sequencer: grants one source at a time, drives select code and transfer
// strobe, and inserts memory wait states while M drives the bus.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NSRC     = 7,
    parameter int unsigned MEM_WAIT = 1,
    parameter bit          RR       = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] req,
    output logic [NSRC-1:0] grant,
    output logic [2:0]      sel,
    output logic            xfer,
    output logic            mem_rd,
    output logic            busy
);

    localparam int unsigned IdxW = $clog2(NSRC);
    localparam int unsigned CntW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [IdxW-1:0] last_q;
    logic [NSRC-1:0] grant_q;
    logic [2:0]      sel_q;
    logic            xfer_q;
    logic            mem_rd_q;
    logic            busy_q;

    logic [NSRC-1:0] mask;
    logic [IdxW-1:0] pick_idx;
    logic            pick_valid;
    logic            pick_is_m;

    // Only the source served in the current XFER cycle is excluded from re-arbitration.
    assign mask      = (state_q == ST_XFER) ? grant_q : '0;
    assign pick_is_m = (pick_idx == IdxW'(SRC_M));

    bus_pick #(
        .NSRC (NSRC),
        .RR   (RR),
        .IdxW (IdxW)
    ) u_pick (
        .req    (req),
        .mask   (mask),
        .last   (last_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= IdxW'(NSRC - 1);
            grant_q  <= '0;
            sel_q    <= SEL_IDLE;
            xfer_q   <= 1'b0;
            mem_rd_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_MWAIT: begin
                    if (!req[SRC_M]) begin
                        state_q  <= ST_IDLE;
                        grant_q  <= '0;
                        sel_q    <= SEL_IDLE;
                        xfer_q   <= 1'b0;
                        mem_rd_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_XFER;
                        xfer_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    // IDLE and XFER both arbitrate; XFER hands over with no bubble.
                    if (pick_valid) begin
                        grant_q <= NSRC'(1) << pick_idx;
                        sel_q   <= sel_encode(32'(pick_idx));
                        busy_q  <= 1'b1;
                        last_q  <= pick_idx;
                        if (pick_is_m && (MEM_WAIT > 0)) begin
                            state_q  <= ST_MWAIT;
                            cnt_q    <= CntW'(MEM_WAIT - 1);
                            xfer_q   <= 1'b0;
                            mem_rd_q <= 1'b1;
                        end else begin
                            state_q  <= ST_XFER;
                            xfer_q   <= 1'b1;
                            mem_rd_q <= pick_is_m;
                        end
                    end else begin
                        state_q  <= ST_IDLE;
                        grant_q  <= '0;
                        sel_q    <= SEL_IDLE;
                        xfer_q   <= 1'b0;
                        mem_rd_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign grant  = grant_q;
    assign sel    = sel_q;
    assign xfer   = xfer_q;
    assign mem_rd = mem_rd_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table on the default build, plus hand sequences on
// round-robin and longer-wait builds for the multi-cycle corner cases.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] req;

    always #5 clk = ~clk;

    localparam logic [6:0] R_AR = 7'b1 << SRC_AR;
    localparam logic [6:0] R_PC = 7'b1 << SRC_PC;
    localparam logic [6:0] R_DR = 7'b1 << SRC_DR;
    localparam logic [6:0] R_AC = 7'b1 << SRC_AC;
    localparam logic [6:0] R_IR = 7'b1 << SRC_IR;
    localparam logic [6:0] R_TR = 7'b1 << SRC_TR;
    localparam logic [6:0] R_M  = 7'b1 << SRC_M;

    // dut0: RR=0 MEM_WAIT=1, dut1: RR=1 MEM_WAIT=0, dut2: MEM_WAIT=2, dut3: MEM_WAIT=3
    logic [6:0] g0, g1, g2, g3;
    logic [2:0] s0, s1, s2, s3;
    logic       x0, x1, x2, x3;
    logic       m0, m1, m2, m3;
    logic       b0, b1, b2, b3;

    bus_arbiter #(.NSRC(7), .MEM_WAIT(1), .RR(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .grant(g0), .sel(s0), .xfer(x0), .mem_rd(m0), .busy(b0)
    );
    bus_arbiter #(.NSRC(7), .MEM_WAIT(0), .RR(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .grant(g1), .sel(s1), .xfer(x1), .mem_rd(m1), .busy(b1)
    );
    bus_arbiter #(.NSRC(7), .MEM_WAIT(2), .RR(1'b0)) dut2 (
        .clk(clk), .rst(rst), .req(req), .grant(g2), .sel(s2), .xfer(x2), .mem_rd(m2), .busy(b2)
    );
    bus_arbiter #(.NSRC(7), .MEM_WAIT(3), .RR(1'b0)) dut3 (
        .clk(clk), .rst(rst), .req(req), .grant(g3), .sel(s3), .xfer(x3), .mem_rd(m3), .busy(b3)
    );

    typedef struct {
        logic [6:0] req;
        logic [6:0] grant;
        logic [2:0] sel;
        logic       xfer;
        logic       mem_rd;
        logic       busy;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{R_AC | R_PC, R_AC, SEL_AC, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{R_PC, R_PC, SEL_PC, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{7'h00, 7'h00, SEL_IDLE, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{R_AR, R_AR, SEL_AR, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{R_AR, 7'h00, SEL_IDLE, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{R_AR, R_AR, SEL_AR, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{R_AR, 7'h00, SEL_IDLE, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{7'h00, 7'h00, SEL_IDLE, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{R_M, R_M, SEL_M, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{R_M, R_M, SEL_M, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{7'h00, 7'h00, SEL_IDLE, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{7'h7F, R_M, SEL_M, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{7'h7F, R_M, SEL_M, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{7'h7F & ~R_M, R_TR, SEL_TR, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{R_IR | R_AC | R_DR | R_PC | R_AR, R_IR, SEL_IR, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{R_DR, R_DR, SEL_DR, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{R_DR, 7'h00, SEL_IDLE, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{7'h00, 7'h00, SEL_IDLE, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        req = '0;
        #12;
        check("reset_outputs", 32'({g0, s0, x0, m0, b0}), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed-priority vectors on dut0
        for (int i = 0; i < NVEC; i++) begin
            req = vecs[i].req;
            cyc();
            check($sformatf("vec%0d", i), 32'({g0, s0, x0, m0, b0}),
                  32'({vecs[i].grant, vecs[i].sel, vecs[i].xfer, vecs[i].mem_rd, vecs[i].busy}));
        end

        // Async reset while dut0 is in its memory wait state
        do_reset();
        req = R_M;
        cyc();
        check("mwait_entry", 32'({g0, s0, x0, m0, b0}), 32'({R_M, SEL_M, 1'b0, 1'b1, 1'b1}));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_mwait", 32'({g0, s0, x0, m0, b0}), 32'h0);
        req = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req = R_AR;
        cyc();
        check("after_rst_ar", 32'({s0, x0}), 32'({SEL_AR, 1'b1}));

        // Round-robin with every source held, no memory wait
        do_reset();
        req = 7'h7F;
        for (int k = 0; k < 8; k++) begin
            cyc();
            check($sformatf("rr_sel%0d", k), 32'(s1), 32'((k % 7) + 1));
            check($sformatf("rr_xfer%0d", k), 32'(x1), 32'h1);
            check($sformatf("rr_mem%0d", k), 32'(m1), (k == 6) ? 32'h1 : 32'h0);
        end

        // Two wait states on M
        do_reset();
        req = R_M;
        cyc();
        check("w2_c1", 32'({s2, m2, x2}), 32'({SEL_M, 1'b1, 1'b0}));
        cyc();
        check("w2_c2", 32'({s2, m2, x2}), 32'({SEL_M, 1'b1, 1'b0}));
        cyc();
        check("w2_c3", 32'({s2, m2, x2}), 32'({SEL_M, 1'b1, 1'b1}));
        req = '0;
        cyc();
        check("w2_c4", 32'({g2, s2, x2, m2, b2}), 32'h0);

        // Three wait states on M, request withdrawn in the second wait cycle
        do_reset();
        req = R_M;
        cyc();
        check("w3_c1", 32'({g3, m3, x3}), 32'({R_M, 1'b1, 1'b0}));
        cyc();
        check("w3_c2", 32'({g3, m3, x3}), 32'({R_M, 1'b1, 1'b0}));
        req = '0;
        cyc();
        check("w3_abort", 32'({g3, s3, m3, b3}), 32'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("w3_noxfer%0d", k), 32'(x3), 32'h0);
            cyc();
        end

        // Single source held continuously: served every second cycle
        do_reset();
        req = R_AR;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("hold_xfer%0d", k), 32'({x0, b0}), (k % 2 == 0) ? 32'h3 : 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
